// File: rtl/bus_pkg.sv
// Shared definitions for the packet router: ID constants, decode result type
// and the ID classification helper used by the top level.
package bus_pkg;

  localparam int unsigned ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  typedef enum logic [1:0] {
    ID_UNICAST,
    ID_BROADCAST,
    ID_INVALID
  } id_kind_t;

  // Classify a destination ID against the number of output channels.
  // The broadcast ID wins even when n_chan is 255, where it would also be
  // out of the unicast range.
  function automatic id_kind_t decode_id(input logic [ID_W-1:0] id,
                                         input int n_chan);
    id_kind_t kind;
    if (id == BROADCAST_ID)
      kind = ID_BROADCAST;
    else if (int'(id) < n_chan)
      kind = ID_UNICAST;
    else
      kind = ID_INVALID;
    return kind;
  endfunction

endpackage

// File: rtl/bus_chan_fifo.sv
// Single first-word-fall-through channel FIFO. The head entry is presented
// combinationally from storage; dout reads 0 while the FIFO is empty.
// Writes to a full FIFO and reads from an empty FIFO are ignored.
module bus_chan_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [width-1:0]           din,
  output logic [width-1:0]           dout,
  output logic [$clog2(depth):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth);

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Qualify requests on the pre-edge state and compute next pointers/count.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch can be inferred on any path.
  always_comb begin
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_ok && !rd_ok)
      count_d = count_q + CNT_W'(1);
    else if (rd_ok && !wr_ok)
      count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers with synchronous reset.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage write port.
  // NOTE: the storage array is deliberately not reset; stale entries are
  // never visible because dout is masked to 0 whenever count is 0.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset)
      mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_pkt_router.sv
// Packet distribution stage: decodes the destination ID in the packet's top
// byte, writes the packet atomically into one channel FIFO or all of them
// (broadcast), and counts rejected packets. Per-channel outputs come from
// FIFO registers only.
module bus_pkt_router
  import bus_pkg::*;
#(
  parameter int width   = 16,
  parameter int depth   = 8,
  parameter int drivers = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [width-1:0]           D_push,
  input  logic [drivers-1:0]         pop,
  output logic [drivers*width-1:0]   D_pop,
  output logic [drivers-1:0]         pndng,
  output logic [drivers-1:0]         full,
  output logic                       err_id,
  output logic [15:0]                drop_cnt
);

  localparam int CNT_W = $clog2(depth) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth);

  logic [ID_W-1:0]    id;
  id_kind_t           kind;
  logic [drivers-1:0] tgt;
  logic [drivers-1:0] tgt_full;
  logic [drivers-1:0] wr_en;
  logic [drivers-1:0] chan_empty;
  logic [drivers-1:0] chan_full;
  logic [CNT_W-1:0]   chan_count [drivers];
  logic [width-1:0]   chan_dout  [drivers];
  logic               accept;
  logic               drop;
  logic               err_id_q, err_id_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  // Decode the target set and decide atomically whether the push is taken.
  // A target counts as full on its pre-edge count, so a same-cycle pop on
  // that channel does not rescue the push.
  always_comb begin
    id    = D_push[width-1 -: ID_W];
    kind  = decode_id(id, drivers);
    tgt   = '0;
    tgt_full = '0;
    for (int i = 0; i < drivers; i++) begin
      tgt[i]      = (kind == ID_BROADCAST) ||
                    ((kind == ID_UNICAST) && (int'(id) == i));
      tgt_full[i] = (chan_count[i] == DEPTH_C);
    end
    accept = push && (kind != ID_INVALID) && !(|(tgt & tgt_full));
    drop   = push && !accept;
    wr_en  = accept ? tgt : '0;
  end

  // Next-state for the error pulse and the saturating drop counter.
  always_comb begin
    err_id_d   = push && (kind == ID_INVALID);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Error pulse and drop counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_id_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      err_id_q   <= err_id_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_id   = err_id_q;
  assign drop_cnt = drop_cnt_q;

  for (genvar g = 0; g < drivers; g++) begin : g_chan
    bus_chan_fifo #(
      .width (width),
      .depth (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en[g]),
      .rd_en (pop[g]),
      .din   (D_push),
      .dout  (chan_dout[g]),
      .count (chan_count[g]),
      .empty (chan_empty[g]),
      .full  (chan_full[g])
    );

    assign D_pop[g*width +: width] = chan_dout[g];
    assign pndng[g]                = !chan_empty[g];
    assign full[g]                 = chan_full[g];
  end

endmodule

// File: tb/tb_bus_pkt_router.sv
// Directed bench for bus_pkt_router (width=16, depth=8, drivers=4).
// A queue-based reference model tracks every channel; a negedge compare
// process checks all outputs against it, and hand-computed literals pin the
// model at the interesting points.
module tb_bus_pkt_router;

  localparam int W = 16;
  localparam int D = 8;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0;
  logic [W-1:0]     D_push = '0;
  logic [N-1:0]     pop = '0;
  logic [N*W-1:0]   D_pop;
  logic [N-1:0]     pndng;
  logic [N-1:0]     full;
  logic             err_id;
  logic [15:0]      drop_cnt;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [W-1:0] mq [N][$];
  int           m_drop = 0;
  bit           m_err  = 1'b0;

  bus_pkt_router #(.width(W), .depth(D), .drivers(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .D_push   (D_push),
    .pop      (pop),
    .D_pop    (D_pop),
    .pndng    (pndng),
    .full     (full),
    .err_id   (err_id),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one edge's worth of stimulus to the reference model.
  task automatic model_update(input bit rst, input bit p,
                              input logic [W-1:0] d, input logic [N-1:0] pv);
    logic [7:0] id;
    bit         is_bc, valid, ok;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_drop = 0;
      m_err  = 1'b0;
      return;
    end
    id    = d[W-1 -: 8];
    is_bc = (id == 8'hFF);
    valid = is_bc || (int'(id) < N);
    m_err = p && !valid;
    ok    = 1'b1;
    for (int i = 0; i < N; i++)
      if ((is_bc || int'(id) == i) && mq[i].size() == D) ok = 1'b0;
    for (int i = 0; i < N; i++)
      if (pv[i] && mq[i].size() > 0) void'(mq[i].pop_front());
    if (p && valid && ok) begin
      for (int i = 0; i < N; i++)
        if (is_bc || int'(id) == i) mq[i].push_back(d);
    end else if (p) begin
      if (m_drop < 16'hFFFF) m_drop++;
    end
  endtask

  // Compare every output against the model midway through each cycle.
  always @(negedge clk) begin
    if (check_en) begin
      logic [N-1:0] ep, ef;
      for (int i = 0; i < N; i++) begin
        ep[i] = mq[i].size() > 0;
        ef[i] = mq[i].size() == D;
        check($sformatf("model D_pop[%0d]", i), 64'(D_pop[i*W +: W]),
              64'(mq[i].size() > 0 ? mq[i][0] : 16'h0000));
      end
      check("model pndng", 64'(pndng), 64'(ep));
      check("model full", 64'(full), 64'(ef));
      check("model err_id", 64'(err_id), 64'(m_err));
      check("model drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  // One clock: drive inputs, take the edge, update the model, then idle.
  task automatic tick(input bit rst, input bit p, input logic [W-1:0] d,
                      input logic [N-1:0] pv);
    reset  = rst;
    push   = p;
    D_push = d;
    pop    = pv;
    @(posedge clk);
    model_update(rst, p, d, pv);
    #1;
    reset = 1'b0;
    push  = 1'b0;
    pop   = '0;
  endtask

  task automatic push_pkt(input logic [W-1:0] d);
    tick(1'b0, 1'b1, d, '0);
  endtask

  // Check the head of a channel, then pop it.
  task automatic pop_expect(input int ch, input logic [W-1:0] exp);
    check($sformatf("drain ch%0d", ch), 64'(D_pop[ch*W +: W]), 64'(exp));
    tick(1'b0, 1'b0, '0, N'(1) << ch);
  endtask

  initial begin
    // 1. Reset held two cycles with a push pending: push ignored.
    tick(1'b1, 1'b1, 16'h01AA, '0);
    check_en = 1'b1;
    tick(1'b1, 1'b1, 16'h01AA, '0);
    check("rst pndng", 64'(pndng), 64'h0);
    check("rst full", 64'(full), 64'h0);
    check("rst drop_cnt", 64'(drop_cnt), 64'h0);
    check("rst err_id", 64'(err_id), 64'h0);
    check("rst D_pop", 64'(D_pop), 64'h0);

    // 2. Unicast to channel 2, then pop it.
    push_pkt(16'h02AB);
    check("uni pndng", 64'(pndng), 64'b0100);
    check("uni head", 64'(D_pop[47:32]), 64'h02AB);
    tick(1'b0, 1'b0, '0, 4'b0100);
    check("uni pop pndng", 64'(pndng), 64'h0);
    check("uni pop head", 64'(D_pop[47:32]), 64'h0);

    // 3. Broadcast reaches every channel.
    push_pkt(16'hFF55);
    check("bc pndng", 64'(pndng), 64'b1111);
    check("bc heads", 64'(D_pop), 64'hFF55_FF55_FF55_FF55);
    tick(1'b0, 1'b0, '0, 4'b1111);

    // 4. Fill channel 1, overflow, partial drain, refill across the wrap.
    for (int k = 0; k < 8; k++) push_pkt(16'h0100 + 16'(k));
    check("fill full[1]", 64'(full), 64'b0010);
    push_pkt(16'h0108);
    check("ovf drop_cnt", 64'(drop_cnt), 64'd1);
    for (int k = 0; k < 3; k++) pop_expect(1, 16'h0100 + 16'(k));
    for (int k = 9; k < 12; k++) push_pkt(16'h0100 + 16'(k));
    for (int k = 3; k < 8; k++) pop_expect(1, 16'h0100 + 16'(k));
    for (int k = 9; k < 12; k++) pop_expect(1, 16'h0100 + 16'(k));
    check("wrap empty", 64'(pndng), 64'h0);

    // 5. Broadcast blocked by a full channel 0: nothing written anywhere.
    push_pkt(16'h0277);
    for (int k = 0; k < 8; k++) push_pkt(16'h0000 + 16'(k));
    push_pkt(16'hFF01);
    check("bc blk pndng", 64'(pndng), 64'b0101);
    check("bc blk ch2", 64'(D_pop[47:32]), 64'h0277);
    check("bc blk drop", 64'(drop_cnt), 64'd2);
    // Push to full channel with a same-cycle pop is still dropped.
    tick(1'b0, 1'b1, 16'h0099, 4'b0001);
    check("full+pop drop", 64'(drop_cnt), 64'd3);
    check("full+pop head", 64'(D_pop[15:0]), 64'h0001);
    check("full+pop full", 64'(full), 64'b0000);

    // Reset mid-operation discards everything.
    tick(1'b1, 1'b1, 16'h0011, 4'b1111);
    check("mid rst pndng", 64'(pndng), 64'h0);
    check("mid rst drop", 64'(drop_cnt), 64'h0);

    // 6. Invalid ID: one-cycle error pulse, counted, nothing written.
    push_pkt(16'h0733);
    check("inv err_id", 64'(err_id), 64'd1);
    check("inv drop", 64'(drop_cnt), 64'd1);
    check("inv pndng", 64'(pndng), 64'h0);
    tick(1'b0, 1'b0, '0, '0);
    check("inv err clr", 64'(err_id), 64'd0);
    push_pkt(16'h0033);
    check("ch0 pndng", 64'(pndng), 64'b0001);
    check("ch0 head", 64'(D_pop[15:0]), 64'h0033);

    // Push+pop on an empty channel: written, pop ignored.
    tick(1'b0, 1'b1, 16'h0344, 4'b1000);
    check("empty pp pndng", 64'(pndng), 64'b1001);
    check("empty pp head", 64'(D_pop[63:48]), 64'h0344);
    // Push+pop on a non-empty channel: head advances, count unchanged.
    tick(1'b0, 1'b1, 16'h0055, 4'b0001);
    check("pp head", 64'(D_pop[15:0]), 64'h0055);
    pop_expect(0, 16'h0055);
    check("pp drained", 64'(pndng), 64'b1000);

    tick(1'b0, 1'b0, '0, '0);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/bus_pkt_router.md
# bus_pkt_router

Parametrised packet distribution stage between the bus agent side and the per-driver receive path. It accepts one packet per cycle on a single push port and decodes the destination ID in the packet's upper byte. It writes the packet into one of `drivers` independent first-word-fall-through FIFOs, or into all of them for the broadcast ID. Drops are atomic and counted, and per-channel pending/full flags are exposed to the consuming drivers.

## Interface
- `width`, default 16: packet width; bits `[width-1 -: 8]` are the destination ID, the remainder is payload; must be ≥ 9.
- `depth`, default 8: entries per channel FIFO; power of two, ≥ 2.
- `drivers`, default 4: number of output channels; 1..255.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `push`  in  1: packet valid this cycle.
- `D_push`  in  width: packet, `{ID, payload}`.
- `pop`  in  drivers: per-channel pop request.
- `D_pop`  out  drivers*width: channel i head at `[i*width +: width]`; 0 when empty.
- `pndng`  out  drivers: channel i non-empty.
- `full`  out  drivers: channel i count == depth.
- `err_id`  out  1: one-cycle pulse on a push with an invalid ID.
- `drop_cnt`  out  16: saturating count of dropped packets.

## Operation
- ID decode: ID < drivers targets that channel only. ID == 8'hFF is broadcast to all channels. Any other ID is invalid: no write, `err_id` pulses, drop counted.
- Atomic accept: a push is written only if every targeted channel is not full, judged on the pre-edge count. If any target is full, nothing is written and `drop_cnt` increments. A broadcast is never partially delivered.
- Push to a full channel is dropped even when that channel pops in the same cycle.
- Pop on an empty channel is ignored; pointers and count are unchanged.
- Simultaneous accepted push and pop on the same non-empty channel: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty channel: the push is written, the pop is ignored, and count becomes 1.
- Pointers are `$clog2(depth)` bits and wrap naturally. Count is `$clog2(depth)+1` bits.
- `drop_cnt` holds at 16'hFFFF.
- Data is stored unmodified; the ID byte is retained in the stored packet.

## Timing
- Reset: on any `clk` edge with `reset`=1, all channel counts and pointers go to 0. Outputs become `pndng`=0, `full`=0, `D_pop`=0, `err_id`=0, `drop_cnt`=0. A push or pop in the same cycle is ignored.
- Reset mid-operation discards all stored packets. Outputs read the reset values starting the cycle after the edge.
- Write latency: a packet accepted at edge N gives `pndng[i]`=1 and the packet on `D_pop[i]` after edge N, i.e. 1 cycle.
- Read: FWFT. `D_pop[i]` shows the head combinationally from storage. `pop[i]` at edge N advances the head, visible after N.
- `full`, `pndng` and `D_pop` derive from registers only; they have no combinational path from `push` or `pop`.
- `err_id` is registered: it is high for exactly the cycle after the offending push edge.
- `drop_cnt` is updated at the same edge as the rejected push.

## Structure
- Shared package `bus_pkg` holds:
  - `BROADCAST_ID` = 8'hFF and `ID_W` = 8;
  - the decode result enum `id_kind_t` {`ID_UNICAST`, `ID_BROADCAST`, `ID_INVALID`}.
- Sub-module `bus_chan_fifo`: one FWFT FIFO with parameters `width` and `depth`.
  - Inputs: `wr_en`, `rd_en`, `din`. Outputs: `dout`, `count`, `empty`, `full`.
  - Instantiated `drivers` times in a generate loop.
- Top level contains the ID decode, the atomic accept logic, the error pulse register and the drop counter.

## Test plan
All cases use width=16, depth=8, drivers=4.
1. Hold `reset` for 2 cycles with `push`=1, `D_push`=16'h01AA -> `pndng`=4'b0000, `full`=0, `drop_cnt`=0, `err_id`=0.
2. Push 16'h02AB -> next cycle `pndng`=4'b0100 and `D_pop[47:32]`=16'h02AB. Pop channel 2 -> `pndng`=0 and `D_pop[47:32]`=0.
3. Push broadcast 16'hFF55 -> next cycle `pndng`=4'b1111 and every channel head = 16'hFF55.
4. Push 16'h0100..16'h0107 to channel 1 -> `full[1]`=1. Push 16'h0108 -> dropped, `drop_cnt`=1. Pop 3, then push 16'h0109..16'h010B and drain -> output order 0103..0107, 0109..010B (wrap verified).
5. Fill channel 0 to full, then push broadcast 16'hFF01 -> no channel written, `pndng[3:1]` unchanged, `drop_cnt` +1.
6. Push 16'h0733 -> `err_id`=1 for exactly one cycle, `drop_cnt` +1, no channel written. Push 16'h0033 in the same test -> normal write to channel 0.
